char_store: RTL and testbench

Write-side sequencer for character/operand buffers. After a `start` pulse it accepts a valid/ready data stream and writes each beat to a buffer memory at consecutive addresses from `start_addr` to `end_addr` inclusive, wrapping modulo 2^ADDR_WIDTH. It pulses `done` after the last write. It fills the buffers that the read-side address incrementer later walks.

---
 rtl/char_store_if.sv | 31 +++
 rtl/char_store.sv | 106 ++++++++++
 tb/tb_char_store.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/char_store_if.sv
// Bundles the request, stream and memory-write signals of the char_store
// fill sequencer. The slave side is the sequencer; the master side drives
// requests and data and observes the write port.
interface char_store_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [ADDR_WIDTH-1:0] end_addr;
  logic                  abort;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH:0]   count;

  modport master (
    output start, start_addr, end_addr, abort, in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data, busy, done, count
  );

  modport slave (
    input  start, start_addr, end_addr, abort, in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data, busy, done, count
  );
endinterface

// File: rtl/char_store.sv
// Write-side sequencer: after a start request it accepts a valid/ready
// stream and writes each beat to consecutive buffer addresses from the
// latched start address to the latched end address (wrapping), then
// pulses done. Abort cancels a fill without a done pulse.
module char_store #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  char_store_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_cur_addr;
  logic [ADDR_WIDTH-1:0] r_last_addr;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic [ADDR_WIDTH:0]   r_count;

  logic w_in_ready;
  logic w_accept;
  logic w_start_ok;
  logic w_last_beat;

  // Ready depends only on state and abort so upstream never sees a
  // combinational path from its own valid.
  assign w_in_ready  = (r_state == S_RUN) && !bus.abort;
  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_start_ok  = (r_state == S_IDLE) && bus.start && !bus.abort;
  // Address equality (not a beat counter) ends the fill, so a full-buffer
  // fill (end = start - 1) naturally runs all 2^ADDR_WIDTH beats.
  assign w_last_beat = w_accept && (r_cur_addr == r_last_addr);

  // Next-state selection; abort returns to IDLE from any state.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_start_ok) w_state_next = S_RUN;
      S_RUN: begin
        if (bus.abort)        w_state_next = S_IDLE;
        else if (w_last_beat) w_state_next = S_DONE;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Current/last address: latched on an honoured start, stepped per beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cur_addr  <= '0;
      r_last_addr <= '0;
    end else if (w_start_ok) begin
      r_cur_addr  <= bus.start_addr;
      r_last_addr <= bus.end_addr;
    end else if (w_accept) begin
      r_cur_addr  <= r_cur_addr + 1'b1;
    end
  end

  // Registered write port: one strobe per accepted beat, one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_accept;
      if (w_accept) begin
        r_wr_addr <= r_cur_addr;
        r_wr_data <= bus.in_data;
      end
    end
  end

  // Beat counter: cleared on start, held after done/abort until next start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_count <= '0;
    else if (w_start_ok) r_count <= '0;
    else if (w_accept)   r_count <= r_count + 1'b1;
  end

  assign bus.in_ready = w_in_ready;
  assign bus.wr_en    = r_wr_en;
  assign bus.wr_addr  = r_wr_addr;
  assign bus.wr_data  = r_wr_data;
  assign bus.busy     = (r_state == S_RUN);
  assign bus.done     = (r_state == S_DONE);
  assign bus.count    = r_count;

endmodule

// File: tb/tb_char_store.sv
// Self-checking bench for char_store: table-driven fills, hand-written
// corner sequences and a random phase, all checked every cycle against a
// behavioural model built from fill length and address arithmetic.
module tb_char_store;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int DEPTH = 1 << AW;

  localparam int P_IDLE = 0;
  localparam int P_RUN  = 1;
  localparam int P_DONE = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  char_store_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  char_store #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model: phase, beats still owed, next address, beats taken,
  // and the write expected on the port this cycle.
  int           m_phase;
  int           m_left;
  int           m_addr;
  int           m_count;
  logic         m_wr_en;
  logic [AW-1:0] m_wr_addr;
  logic [DW-1:0] m_wr_data;

  // Observations gathered while a table vector runs.
  int           obs_writes;
  logic         obs_done;
  logic [AW-1:0] obs_first;
  logic [AW-1:0] obs_last;

  typedef struct {
    logic [AW-1:0] sa;
    logic [AW-1:0] ea;
    logic [31:0]   pat;
    logic [DW-1:0] base;
    int            start_mid;
    int            abort_at;
    int            exp_count;
    int            exp_writes;
    logic          exp_done;
    logic [AW-1:0] exp_first;
    logic [AW-1:0] exp_last;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase   = P_IDLE;
    m_left    = 0;
    m_addr    = 0;
    m_count   = 0;
    m_wr_en   = 1'b0;
    m_wr_addr = '0;
    m_wr_data = '0;
  endtask

  // One clock cycle: drive inputs, compare every output with the model,
  // advance the model across the edge. Entered and left at posedge+1.
  task automatic cycle(input logic st, input logic [AW-1:0] sa, input logic [AW-1:0] ea,
                       input logic ab, input logic v, input logic [DW-1:0] d);
    logic          e_ready;
    logic          accept;
    logic [20:0]   act;
    logic [20:0]   exp;
    bus.start      = st;
    bus.start_addr = sa;
    bus.end_addr   = ea;
    bus.abort      = ab;
    bus.in_valid   = v;
    bus.in_data    = d;
    #1;
    e_ready = (m_phase == P_RUN) && !ab;
    exp = {e_ready, m_phase == P_RUN, m_phase == P_DONE, m_wr_en, 5'(m_count),
           m_wr_en ? m_wr_addr : 4'h0, m_wr_en ? m_wr_data : 8'h00};
    act = {bus.in_ready, bus.busy, bus.done, bus.wr_en, bus.count,
           m_wr_en ? bus.wr_addr : 4'h0, m_wr_en ? bus.wr_data : 8'h00};
    check("cycle rdy/busy/done/wen/cnt/addr/data", 32'(act), 32'(exp));
    if (bus.wr_en) begin
      if (obs_writes == 0) obs_first = bus.wr_addr;
      obs_last = bus.wr_addr;
      obs_writes++;
    end
    if (bus.done) obs_done = 1'b1;

    accept  = v && e_ready;
    m_wr_en = accept;
    if (accept) begin
      m_wr_addr = AW'(m_addr);
      m_wr_data = d;
    end
    if (m_phase == P_IDLE) begin
      if (st && !ab) begin
        m_phase = P_RUN;
        m_addr  = int'(sa);
        m_left  = ((int'(ea) - int'(sa) + DEPTH) % DEPTH) + 1;
        m_count = 0;
      end
    end else if (m_phase == P_RUN) begin
      if (ab) m_phase = P_IDLE;
      else if (accept) begin
        m_count++;
        m_addr = (m_addr + 1) % DEPTH;
        m_left--;
        if (m_left == 0) m_phase = P_DONE;
      end
    end else begin
      m_phase = P_IDLE;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // sa, ea, valid pattern, data base, start_mid, abort_at, count, writes, done, first, last
    vecs[0] = '{4'd2,  4'd5,  32'hFFFF_FFFF, 8'hA0, -1, -1,  4,  4, 1'b1, 4'd2,  4'd5};
    vecs[1] = '{4'd14, 4'd1,  32'hFFFF_FFFF, 8'h10, -1, -1,  4,  4, 1'b1, 4'd14, 4'd1};
    vecs[2] = '{4'd3,  4'd2,  32'hFFFF_FFFF, 8'h40, -1, -1, 16, 16, 1'b1, 4'd3,  4'd2};
    vecs[3] = '{4'd7,  4'd7,  32'hFFFF_FFFF, 8'h77, -1, -1,  1,  1, 1'b1, 4'd7,  4'd7};
    vecs[4] = '{4'd4,  4'd7,  32'h0000_0059, 8'hC0,  2, -1,  4,  4, 1'b1, 4'd4,  4'd7};
    vecs[5] = '{4'd0,  4'd5,  32'hFFFF_FFFF, 8'h50, -1,  2,  2,  2, 1'b0, 4'd0,  4'd1};
    vecs[6] = '{4'd9,  4'd11, 32'hFFFF_FFFF, 8'h90, -1, -1,  3,  3, 1'b1, 4'd9,  4'd11};

    model_reset();
    bus.start = 0; bus.start_addr = '0; bus.end_addr = '0;
    bus.abort = 0; bus.in_valid = 0; bus.in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", 32'({bus.in_ready, bus.busy, bus.done, bus.wr_en,
                                bus.count, bus.wr_addr, bus.wr_data}), 32'h0);
    rst = 1'b0;
    cycle(0, 0, 0, 0, 0, 0);

    // Table-driven fills; vector 6 starts the cycle right after vector 5's abort.
    for (int vi = 0; vi < 7; vi++) begin
      int k;
      int guard;
      obs_writes = 0;
      obs_done   = 1'b0;
      obs_first  = '0;
      obs_last   = '0;
      cycle(1, vecs[vi].sa, vecs[vi].ea, 0, 0, 0);
      k = 0;
      guard = 0;
      while (m_phase != P_IDLE && guard < 60) begin
        logic st;
        logic ab;
        st = (k == vecs[vi].start_mid);
        ab = (vecs[vi].abort_at >= 0) && (m_count == vecs[vi].abort_at);
        cycle(st, st ? 4'd0 : vecs[vi].sa, st ? 4'd15 : vecs[vi].ea, ab,
              vecs[vi].pat[k % 32], vecs[vi].base + DW'(m_count));
        k++;
        guard++;
      end
      if (guard >= 60) begin
        checks++;
        errors++;
        $display("FAIL vec%0d timeout: fill still active after %0d cycles, required idle", vi, guard);
      end
      check($sformatf("vec%0d count", vi), 32'(bus.count), 32'(vecs[vi].exp_count));
      check($sformatf("vec%0d writes", vi), 32'(obs_writes), 32'(vecs[vi].exp_writes));
      check($sformatf("vec%0d done", vi), 32'(obs_done), 32'(vecs[vi].exp_done));
      check($sformatf("vec%0d first addr", vi), 32'(obs_first), 32'(vecs[vi].exp_first));
      check($sformatf("vec%0d last addr", vi), 32'(obs_last), 32'(vecs[vi].exp_last));
    end

    // start and abort together in IDLE: abort wins.
    cycle(1, 4'd3, 4'd4, 1, 1, 8'h11);
    cycle(0, 0, 0, 0, 1, 8'h12);
    check("start+abort busy", 32'(bus.busy), 32'h0);

    // Random phase against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 6) == 0, AW'($urandom), AW'($urandom),
            ($urandom % 20) == 0, ($urandom % 4) != 0, DW'($urandom));
    end
    repeat (20) cycle(0, 0, 0, 0, 1, 8'h33);

    // Reset in the middle of a fill: outputs clear before the next edge.
    cycle(1, 4'd1, 4'd9, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 8'hE0);
    cycle(0, 0, 0, 0, 1, 8'hE1);
    bus.in_valid = 1'b1;
    rst = 1'b1;
    #1;
    check("mid-fill reset outputs", 32'({bus.in_ready, bus.busy, bus.done, bus.wr_en,
                                         bus.count, bus.wr_addr, bus.wr_data}), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    cycle(0, 0, 0, 0, 1, 8'hE2);
    cycle(0, 0, 0, 0, 1, 8'hE3);
    check("post-reset no write", 32'(bus.wr_en), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
